bounce_sequencer: RTL and testbench
===================================

BOUNCE_SEQUENCER -- requirements
Module: bounce_sequencer

Interface
REQ-001 The block SHALL have parameter N, default 4, giving the counter width in bits.
REQ-002 The block SHALL have parameter CW, default 8, giving the width of the period counter.
REQ-003 Port clk, input, 1 bit: the single clock; all state SHALL update on its rising edge.
REQ-004 Port rst, input, 1 bit: reset, asynchronous and active-low.
REQ-005 Port start, input, 1 bit: request to begin sequencing; sampled only in IDLE.
REQ-006 Port stop, input, 1 bit: request to abort; sampled in every state.
REQ-007 Port lo_lim, input, N bits: lower turn-around value.
REQ-008 Port hi_lim, input, N bits: upper turn-around value.
REQ-009 Port dwell, input, 4 bits: hold time at each limit.
REQ-010 Port n_periods, input, CW bits: number of periods to run; 0 means run until stop.
REQ-011 Port count, input, N bits: current value of the downstream up/down counter.
REQ-012 Port enable, output, 1 bit: drives the counter's enable input.
REQ-013 Port up_down, output, 1 bit: drives the counter's direction input; 1 = up, 0 = down.
REQ-014 Port busy, output, 1 bit: high whenever the state is not IDLE.
REQ-015 Port period_done, output, 1 bit: one-cycle pulse at the end of each full period.
REQ-016 Port periods, output, CW bits: number of periods completed since the last start.
REQ-017 Port cfg_err, output, 1 bit: one-cycle pulse when start is rejected.

Function
REQ-018 States SHALL be IDLE, UP, HOLD_HI, DOWN and HOLD_LO.
REQ-019 All outputs SHALL be registered or decoded from registered state only; there SHALL be no combinational path from any input to any output.
REQ-020 State outputs SHALL be: UP gives enable=1, up_down=1; DOWN gives enable=1, up_down=0; IDLE and both HOLD states give enable=0, with up_down keeping its last value.
REQ-021 On start in IDLE, lo_lim, hi_lim, dwell and n_periods SHALL be latched; later changes to these inputs SHALL be ignored until the next start.
REQ-022 On start in IDLE with lo_lim >= hi_lim, the state SHALL stay IDLE and cfg_err SHALL pulse for one cycle.
REQ-023 On a valid start, the next state SHALL be UP if count < hi_lim, otherwise DOWN; periods SHALL clear to 0.
REQ-024 In UP, when count == hi-1 the next state SHALL be HOLD_HI, so the counter lands exactly on hi.
REQ-025 In DOWN, when count == lo+1 the next state SHALL be HOLD_LO, so the counter lands exactly on lo.
REQ-026 Each HOLD state SHALL last dwell+1 cycles, then go to the opposite run state (HOLD_HI to DOWN, HOLD_LO to UP).
REQ-027 On leaving HOLD_LO, periods SHALL increment, saturating at 2^CW-1, and period_done SHALL pulse for one cycle.
REQ-028 If n_periods != 0 and the incremented periods value equals n_periods, the exit from HOLD_LO SHALL go to IDLE instead of UP.
REQ-029 stop SHALL force IDLE at the next edge from any state, so enable=0 on the following cycle; stop SHALL have priority over start and over every transition.
REQ-030 A stop in HOLD_LO on its final cycle SHALL still count the period and pulse period_done.
REQ-031 A start while not IDLE SHALL be ignored.
REQ-032 Steady-state period SHALL be 2*(hi-lo) + 2*(dwell+1) cycles.

Reset
REQ-033 While rst=0: state=IDLE, enable=0, up_down=1, busy=0, period_done=0, cfg_err=0, periods=0, and the dwell timer and latched configuration cleared.
REQ-034 Reset assertion mid-run SHALL take effect immediately without waiting for a clock edge; after release the block SHALL wait in IDLE for start.

Structure
REQ-035 The state encoding, default N and CW, and the dwell width SHALL be defined in the shared package seq_pkg.
REQ-036 The hold countdown SHALL be a sub-module dwell_timer with inputs load and value and output expired.

Verification
REQ-037 rst low mid-UP with count=5 -> enable=0 and state IDLE before the next edge; count then holds at 5.
REQ-038 lo=3, hi=12, dwell=2, n_periods=0, count=0, start -> enable high for 12 cycles, count reaches 12, 3 hold cycles, down to 3, 3 hold cycles, period_done pulses; thereafter a 24-cycle period.
REQ-039 lo=3, hi=12, n_periods=2 -> exactly 2 period_done pulses, periods=2, busy drops, count rests at 3.
REQ-040 lo=9, hi=4, start -> cfg_err pulses once, busy stays 0, enable stays 0.
REQ-041 Start and stop in the same cycle, then stop mid-DOWN at count=7 -> state stays IDLE on the first; enable=0 one cycle after stop on the second, with count at 6.
REQ-042 dwell=0, count=15, hi=12 -> start enters DOWN; each HOLD lasts 1 cycle.

Source files
------------

// File: rtl/seq_pkg.sv
// Shared state encoding and default widths for the bounce sequencer.
package seq_pkg;

  localparam int N_DEF   = 4;
  localparam int CW_DEF  = 8;
  localparam int DWELL_W = 4;

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_UP      = 3'd1,
    S_HOLD_HI = 3'd2,
    S_DOWN    = 3'd3,
    S_HOLD_LO = 3'd4
  } state_e;

endpackage

// File: rtl/dwell_timer.sv
// Hold countdown: reloads while load is high, then counts down to zero.
// expired is high once the count reaches zero, so a hold lasts value+1 cycles.
module dwell_timer
  import seq_pkg::*;
(
  input  logic               clk,
  input  logic               rst,
  input  logic               load,
  input  logic [DWELL_W-1:0] value,
  output logic               expired
);

  logic [DWELL_W-1:0] cnt_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt_q <= '0;
    end else if (load) begin
      cnt_q <= value;
    end else if (cnt_q != '0) begin
      cnt_q <= cnt_q - DWELL_W'(1);
    end
  end

  assign expired = (cnt_q == '0);

endmodule

// File: rtl/bounce_sequencer.sv
// Drives an external up/down counter back and forth between two latched limits,
// holding at each limit for dwell+1 cycles and counting completed periods.
module bounce_sequencer
  import seq_pkg::*;
#(
  parameter int N  = N_DEF,
  parameter int CW = CW_DEF
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic               stop,
  input  logic [N-1:0]       lo_lim,
  input  logic [N-1:0]       hi_lim,
  input  logic [DWELL_W-1:0] dwell,
  input  logic [CW-1:0]      n_periods,
  input  logic [N-1:0]       count,
  output logic               enable,
  output logic               up_down,
  output logic               busy,
  output logic               period_done,
  output logic [CW-1:0]      periods,
  output logic               cfg_err
);

  state_e             state_q;
  logic [N-1:0]       lo_q;
  logic [N-1:0]       hi_q;
  logic [DWELL_W-1:0] dwell_q;
  logic [CW-1:0]      nper_q;
  logic [CW-1:0]      periods_q;
  logic [CW-1:0]      periods_d;
  logic               up_down_q;
  logic               period_done_q;
  logic               cfg_err_q;
  logic               timer_load;
  logic               timer_expired;
  logic               hold_lo_exit;

  // The timer is reloaded in every non-hold state, so it is primed on HOLD entry.
  assign timer_load = (state_q != S_HOLD_HI) && (state_q != S_HOLD_LO);

  dwell_timer u_dwell_timer (
    .clk     (clk),
    .rst     (rst),
    .load    (timer_load),
    .value   (dwell_q),
    .expired (timer_expired)
  );

  assign hold_lo_exit = (state_q == S_HOLD_LO) && timer_expired;
  assign periods_d    = (periods_q == {CW{1'b1}}) ? periods_q : periods_q + CW'(1);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q       <= S_IDLE;
      lo_q          <= '0;
      hi_q          <= '0;
      dwell_q       <= '0;
      nper_q        <= '0;
      periods_q     <= '0;
      up_down_q     <= 1'b1;
      period_done_q <= 1'b0;
      cfg_err_q     <= 1'b0;
    end else begin
      period_done_q <= 1'b0;
      cfg_err_q     <= 1'b0;

      // Counted before the stop override so a stop on the last hold cycle still scores.
      if (hold_lo_exit) begin
        periods_q     <= periods_d;
        period_done_q <= 1'b1;
      end

      if (stop) begin
        state_q <= S_IDLE;
      end else begin
        case (state_q)
          S_IDLE: begin
            if (start) begin
              if (lo_lim >= hi_lim) begin
                cfg_err_q <= 1'b1;
              end else begin
                lo_q      <= lo_lim;
                hi_q      <= hi_lim;
                dwell_q   <= dwell;
                nper_q    <= n_periods;
                periods_q <= '0;
                if (count < hi_lim) begin
                  state_q   <= S_UP;
                  up_down_q <= 1'b1;
                end else begin
                  state_q   <= S_DOWN;
                  up_down_q <= 1'b0;
                end
              end
            end
          end
          S_UP: begin
            if (count == hi_q - N'(1)) state_q <= S_HOLD_HI;
          end
          S_HOLD_HI: begin
            if (timer_expired) begin
              state_q   <= S_DOWN;
              up_down_q <= 1'b0;
            end
          end
          S_DOWN: begin
            if (count == lo_q + N'(1)) state_q <= S_HOLD_LO;
          end
          S_HOLD_LO: begin
            if (timer_expired) begin
              if ((nper_q != '0) && (periods_d == nper_q)) begin
                state_q <= S_IDLE;
              end else begin
                state_q   <= S_UP;
                up_down_q <= 1'b1;
              end
            end
          end
          default: state_q <= S_IDLE;
        endcase
      end
    end
  end

  assign enable      = (state_q == S_UP) || (state_q == S_DOWN);
  assign busy        = (state_q != S_IDLE);
  assign up_down     = up_down_q;
  assign period_done = period_done_q;
  assign periods     = periods_q;
  assign cfg_err     = cfg_err_q;

endmodule

// File: tb/tb_bounce_sequencer.sv
// Scoreboard bench: a phase-length model predicts every output cycle of each run.
module tb_bounce_sequencer;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       start = 1'b0;
  logic       stop = 1'b0;
  logic [3:0] lo_lim = '0;
  logic [3:0] hi_lim = '0;
  logic [3:0] dwell = '0;
  logic [7:0] n_periods = '0;
  logic [3:0] count;
  logic       enable, up_down, busy, period_done, cfg_err;
  logic [7:0] periods;
  logic       ld = 1'b0;
  logic [3:0] ld_val = '0;

  int n_cmp = 0;
  int n_err = 0;
  int m_per = 0;
  bit m_ud  = 1'b1;

  typedef struct packed {
    logic       en;
    logic       ud;
    logic       bsy;
    logic       pd;
    logic       ce;
    logic [7:0] per;
    logic [3:0] cnt;
  } obs_t;

  obs_t exp_q[$];

  localparam int K_UP = 0, K_HH = 1, K_DN = 2, K_HL = 3;

  always #5 clk = ~clk;

  bounce_sequencer dut (
    .clk         (clk),
    .rst         (rst),
    .start       (start),
    .stop        (stop),
    .lo_lim      (lo_lim),
    .hi_lim      (hi_lim),
    .dwell       (dwell),
    .n_periods   (n_periods),
    .count       (count),
    .enable      (enable),
    .up_down     (up_down),
    .busy        (busy),
    .period_done (period_done),
    .periods     (periods),
    .cfg_err     (cfg_err)
  );

  // Downstream up/down counter driven by the sequencer.
  always @(posedge clk) begin
    if (ld) count <= ld_val;
    else if (enable) count <= up_down ? count + 4'd1 : count - 4'd1;
  end

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", name, got, exp);
    end
  endtask

  task automatic push(input bit en, input bit ud, input bit bsy, input bit pd, input bit ce,
                      input int per, input int cnt);
    obs_t o;
    o.en  = en;
    o.ud  = ud;
    o.bsy = bsy;
    o.pd  = pd;
    o.ce  = ce;
    o.per = 8'(per);
    o.cnt = 4'(cnt);
    exp_q.push_back(o);
  endtask

  // Builds the expected trace from segment lengths: climb hi-c, hold dwell+1,
  // descend hi-lo, hold dwell+1, repeat. Returns the number of busy cycles.
  task automatic model_run(input int lo, input int hi, input int dw, input int np,
                           input int c0, input int stop_at, input bit sc, output int nbusy);
    int  kind, rem, cnt, i;
    bit  pd, fin;
    nbusy = 0;
    if (sc) begin
      push(0, m_ud, 0, 0, 0, m_per, c0);
      push(0, m_ud, 0, 0, 0, m_per, c0);
      return;
    end
    if (lo >= hi) begin
      push(0, m_ud, 0, 0, 1, m_per, c0);
      push(0, m_ud, 0, 0, 0, m_per, c0);
      return;
    end
    m_per = 0;
    cnt   = c0;
    pd    = 1'b0;
    if (c0 < hi) begin kind = K_UP; rem = hi - c0; m_ud = 1'b1; end
    else         begin kind = K_DN; rem = c0 - lo; m_ud = 1'b0; end
    i   = 0;
    fin = 1'b0;
    while (!fin) begin
      push((kind == K_UP) || (kind == K_DN), m_ud, 1, pd, 0, m_per, cnt);
      pd = 1'b0;
      if (kind == K_UP) cnt++;
      else if (kind == K_DN) cnt--;
      rem--;
      if (rem == 0 && kind == K_HL) begin
        m_per = (m_per == 255) ? 255 : m_per + 1;
        pd    = 1'b1;
      end
      if (i == stop_at || (rem == 0 && kind == K_HL && np != 0 && m_per == np)) begin
        fin = 1'b1;
      end else if (rem == 0) begin
        case (kind)
          K_UP:    begin kind = K_HH; rem = dw + 1; end
          K_HH:    begin kind = K_DN; rem = hi - lo; m_ud = 1'b0; end
          K_DN:    begin kind = K_HL; rem = dw + 1; end
          default: begin kind = K_UP; rem = hi - lo; m_ud = 1'b1; end
        endcase
      end
      i++;
    end
    nbusy = i;
    push(0, m_ud, 0, pd, 0, m_per, cnt);
    push(0, m_ud, 0, 0, 0, m_per, cnt);
  endtask

  // Monitor: pops one expected observation per clock while a run is in flight.
  initial begin : monitor
    obs_t e, a;
    int   idx;
    idx = 0;
    forever begin
      @(posedge clk);
      #1;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        a = {enable, up_down, busy, period_done, cfg_err, periods, count};
        n_cmp++;
        if (a !== e) begin
          n_err++;
          $display("FAIL trace[%0d] en/ud/busy/pd/cerr/periods/count got %b/%b/%b/%b/%b/%0d/%0d expected %b/%b/%b/%b/%b/%0d/%0d",
                   idx, a.en, a.ud, a.bsy, a.pd, a.ce, a.per, a.cnt,
                   e.en, e.ud, e.bsy, e.pd, e.ce, e.per, e.cnt);
        end
        idx++;
      end
    end
  end

  task automatic do_run(input int lo, input int hi, input int dw, input int np,
                        input int c0, input int stop_at, input bit sc);
    int nbusy, n;
    @(negedge clk);
    ld     = 1'b1;
    ld_val = 4'(c0);
    @(negedge clk);
    ld        = 1'b0;
    lo_lim    = 4'(lo);
    hi_lim    = 4'(hi);
    dwell     = 4'(dw);
    n_periods = 8'(np);
    start     = 1'b1;
    stop      = sc;
    model_run(lo, hi, dw, np, c0, stop_at, sc, nbusy);
    n = exp_q.size();
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      start     = (i < nbusy) ? 1'($urandom_range(0, 1)) : 1'b0;
      stop      = (i == stop_at) && (i < nbusy);
      lo_lim    = 4'($urandom_range(0, 15));
      hi_lim    = 4'($urandom_range(0, 15));
      dwell     = 4'($urandom_range(0, 15));
      n_periods = 8'($urandom_range(0, 255));
    end
    @(negedge clk);
    start = 1'b0;
    stop  = 1'b0;
    chk("trace_drained", 32'(exp_q.size()), 32'd0);
    exp_q.delete();
  endtask

  initial begin : stimulus
    int k, lo, hi, dw, np, c0, sa;
    ld     = 1'b1;
    ld_val = 4'd0;
    repeat (3) @(negedge clk);
    chk("rst_enable", 32'(enable), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_up_down", 32'(up_down), 32'd1);
    chk("rst_periods", 32'(periods), 32'd0);
    chk("rst_period_done", 32'(period_done), 32'd0);
    chk("rst_cfg_err", 32'(cfg_err), 32'd0);
    rst = 1'b1;
    ld  = 1'b0;
    @(negedge clk);

    do_run(3, 12, 2, 0, 0, 80, 0);
    do_run(3, 12, 2, 2, 0, -1, 0);
    do_run(9, 4, 2, 0, 3, -1, 0);
    do_run(5, 5, 1, 0, 2, -1, 0);
    do_run(3, 12, 2, 0, 4, -1, 1);
    do_run(3, 12, 2, 0, 15, 8, 0);
    do_run(3, 12, 2, 0, 0, 26, 0);
    do_run(0, 1, 0, 0, 0, 1050, 0);

    // Asynchronous reset in the middle of a climb.
    @(negedge clk);
    ld     = 1'b1;
    ld_val = 4'd0;
    @(negedge clk);
    ld        = 1'b0;
    lo_lim    = 4'd3;
    hi_lim    = 4'd12;
    dwell     = 4'd2;
    n_periods = 8'd0;
    start     = 1'b1;
    @(negedge clk);
    start = 1'b0;
    k = 0;
    while (k < 40 && count != 4'd5) begin
      @(negedge clk);
      k++;
    end
    chk("mid_up_count", 32'(count), 32'd5);
    chk("mid_up_enable", 32'(enable), 32'd1);
    #2 rst = 1'b0;
    #1;
    chk("async_rst_enable", 32'(enable), 32'd0);
    chk("async_rst_busy", 32'(busy), 32'd0);
    chk("async_rst_up_down", 32'(up_down), 32'd1);
    repeat (3) @(negedge clk);
    chk("async_rst_count_held", 32'(count), 32'd5);
    rst   = 1'b1;
    m_per = 0;
    m_ud  = 1'b1;
    repeat (3) @(negedge clk);
    chk("post_rst_idle_busy", 32'(busy), 32'd0);
    chk("post_rst_idle_count", 32'(count), 32'd5);

    do_run(3, 12, 0, 1, 15, -1, 0);

    for (int r = 0; r < 20; r++) begin
      lo = $urandom_range(0, 15);
      hi = $urandom_range(0, 15);
      dw = $urandom_range(0, 15);
      np = $urandom_range(0, 3);
      c0 = $urandom_range(0, 15);
      if (np == 0) sa = $urandom_range(0, 120);
      else sa = ($urandom_range(0, 1) == 1) ? $urandom_range(0, 150) : -1;
      do_run(lo, hi, dw, np, c0, sa, ($urandom_range(0, 7) == 0));
    end

    repeat (2) @(negedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
